// File: rtl/encoder_7seg_if.sv
// Digit/segment bundle between the display-value logic and the 7-segment encoder.
// The master drives the digit and enable; the slave returns the registered segment drive.
interface encoder_7seg_if;
    logic [3:0] bcd;
    logic       enable;
    logic [6:0] segments;

    modport master (output bcd, output enable, input segments);
    modport slave  (input bcd, input enable, output segments);
endinterface

// File: rtl/encoder_7seg.sv
// Hex nibble to seven-segment driver with a registered, polarity-selectable output.
// Segment bit map is {g,f,e,d,c,b,a}. Letters are drawn as A b C d E F.
module encoder_7seg #(
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    encoder_7seg_if.slave  bus
);

    // Segment pattern that lights nothing for this board's drive polarity.
    localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'b1111111 : 7'b0000000;

    logic [6:0] seg_d;
    logic [6:0] seg_q;

    function automatic logic [6:0] decode_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            4'hF:    s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Polarity is folded in here so the pins are driven straight from flops.
    always_comb begin
        seg_d = SEG_OFF;
        if (bus.enable) begin
            seg_d = decode_hex(bus.bcd) ^ SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign bus.segments = seg_q;

endmodule

// File: tb/tb_encoder_7seg.sv
// Directed bench for encoder_7seg: one common-cathode and one common-anode
// instance receive identical stimulus; outputs are compared to hand-written patterns.
module tb_encoder_7seg;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    encoder_7seg_if if_cc ();
    encoder_7seg_if if_ca ();

    encoder_7seg #(.COMMON_ANODE(1'b0)) u_cc (.clk(clk), .rst_n(rst_n), .bus(if_cc));
    encoder_7seg #(.COMMON_ANODE(1'b1)) u_ca (.clk(clk), .rst_n(rst_n), .bus(if_ca));

    always #5 clk = ~clk;

    // Active-high patterns {g,f,e,d,c,b,a} for digits 0..F.
    logic [6:0] table_ah [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    task automatic drive(input logic [3:0] b, input logic en);
        if_cc.bcd = b;  if_cc.enable = en;
        if_ca.bcd = b;  if_ca.enable = en;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks both instances; the common-anode expectation is given explicitly.
    task automatic chk2(input string tag, input logic [6:0] exp_cc, input logic [6:0] exp_ca);
        chk({tag, "_cc"}, if_cc.segments, exp_cc);
        chk({tag, "_ca"}, if_ca.segments, exp_ca);
    endtask

    task automatic step(input logic [3:0] b, input logic en);
        @(negedge clk);
        drive(b, en);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'h8, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk2("reset", 7'b0000000, 7'b1111111);

        // Release reset and sweep all digits.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b1);
            chk2($sformatf("sweep_%0h", i), table_ah[i], ~table_ah[i]);
        end

        // Spot checks with literal patterns.
        step(4'h0, 1'b1);
        chk2("digit0", 7'b0111111, 7'b1000000);
        step(4'h1, 1'b1);
        chk2("digit1", 7'b0000110, 7'b1111001);

        // Blanking.
        step(4'h8, 1'b1);
        chk2("blank_pre", 7'b1111111, 7'b0000000);
        step(4'h8, 1'b0);
        chk2("blank_off", 7'b0000000, 7'b1111111);
        step(4'h8, 1'b1);
        chk2("blank_on", 7'b1111111, 7'b0000000);

        // Latency: a mid-cycle input change must not reach the pins before the edge.
        step(4'h3, 1'b1);
        chk2("lat_3", 7'b1001111, 7'b0110000);
        @(negedge clk);
        drive(4'h4, 1'b1);
        #2;
        chk2("lat_hold", 7'b1001111, 7'b0110000);
        @(posedge clk);
        #1;
        chk2("lat_4", 7'b1100110, 7'b0011001);

        // Unknown input followed by a valid one must fully recover.
        step(4'bxxxx, 1'b1);
        step(4'h5, 1'b1);
        chk2("x_recover", 7'b1101101, 7'b0010010);

        // Reset has priority over an enabled digit.
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h8, 1'b1);
        @(posedge clk);
        #1;
        chk2("rst_prio", 7'b0000000, 7'b1111111);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk2("rst_release", 7'b1111111, 7'b0000000);

        // Letters after reset release.
        step(4'hB, 1'b1);
        chk2("letter_b", 7'b1111100, 7'b0000011);
        step(4'hD, 1'b1);
        chk2("letter_d", 7'b1011110, 7'b0100001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
